// File: rtl/wall_spawn_ctrl.sv
// Wall spawn scheduler: paces spawns by frame count, draws heights from an external LFSR with
// bounded rejection sampling, and offers each wall to the renderer over valid/ready.
module wall_spawn_ctrl #(
  parameter int unsigned SPAWN_PERIOD = 90,
  parameter int unsigned MIN_H        = 4,
  parameter int unsigned MAX_H        = 40,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned FALLBACK_H   = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_frame_tick,
  input  logic [5:0] i_rand_in,
  output logic       o_rand_step,
  input  logic       i_wall_ready,
  output logic       o_wall_valid,
  output logic [5:0] o_wall_height,
  output logic       o_wall_fallback,
  output logic       o_missed_spawn,
  output logic [7:0] o_spawn_count
);

  localparam logic [7:0] LastFrame = 8'(SPAWN_PERIOD - 1);
  localparam logic [5:0] MinH      = 6'(MIN_H);
  localparam logic [5:0] MaxH      = 6'(MAX_H);
  localparam logic [2:0] RetryMax  = 3'(MAX_RETRY);
  localparam logic [5:0] FallbackH = 6'(FALLBACK_H);

  typedef enum logic [2:0] {StIdle, StWait, StStep, StSample, StOffer} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_frame_cnt, w_frame_cnt_d;
  logic [2:0] r_retry_cnt, w_retry_cnt_d;
  logic [5:0] r_height, w_height_d;
  logic       r_fallback, w_fallback_d;
  logic       r_missed, w_missed_d;
  logic [7:0] r_spawn_count, w_spawn_count_d;
  logic       w_expire;
  logic       w_in_range;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_frame_cnt   <= '0;
      r_retry_cnt   <= '0;
      r_height      <= '0;
      r_fallback    <= 1'b0;
      r_missed      <= 1'b0;
      r_spawn_count <= '0;
    end else begin
      r_state       <= w_state_d;
      r_frame_cnt   <= w_frame_cnt_d;
      r_retry_cnt   <= w_retry_cnt_d;
      r_height      <= w_height_d;
      r_fallback    <= w_fallback_d;
      r_missed      <= w_missed_d;
      r_spawn_count <= w_spawn_count_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_frame_cnt_d   = r_frame_cnt;
    w_retry_cnt_d   = r_retry_cnt;
    w_height_d      = r_height;
    w_fallback_d    = r_fallback;
    w_spawn_count_d = r_spawn_count;
    w_expire        = i_frame_tick && (r_state != StIdle) && (r_frame_cnt == LastFrame);
    w_in_range      = (i_rand_in >= MinH) && (i_rand_in <= MaxH);
    // An expiry while a spawn is still in flight is dropped, only flagged.
    w_missed_d      = w_expire && (r_state != StWait);

    if (i_frame_tick && (r_state != StIdle)) begin
      w_frame_cnt_d = w_expire ? 8'd0 : r_frame_cnt + 8'd1;
    end

    unique case (r_state)
      StIdle: begin
        if (i_enable) begin
          w_state_d       = StStep;
          w_frame_cnt_d   = '0;
          w_spawn_count_d = '0;
        end
      end
      StWait: begin
        if (w_expire) w_state_d = StStep;
      end
      StStep: w_state_d = StSample;
      StSample: begin
        if (w_in_range) begin
          w_height_d    = i_rand_in;
          w_fallback_d  = 1'b0;
          w_retry_cnt_d = '0;
          w_state_d     = StOffer;
        end else if (r_retry_cnt < RetryMax) begin
          w_retry_cnt_d = r_retry_cnt + 3'd1;
          w_state_d     = StStep;
        end else begin
          w_height_d    = FallbackH;
          w_fallback_d  = 1'b1;
          w_retry_cnt_d = '0;
          w_state_d     = StOffer;
        end
      end
      StOffer: begin
        if (i_wall_ready) begin
          w_spawn_count_d = r_spawn_count + 8'd1;
          w_state_d       = StWait;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Disable cancels everything in flight but keeps the last height and the count.
    if (!i_enable) begin
      w_state_d       = StIdle;
      w_frame_cnt_d   = '0;
      w_retry_cnt_d   = '0;
      w_height_d      = r_height;
      w_fallback_d    = r_fallback;
      w_missed_d      = 1'b0;
      w_spawn_count_d = r_spawn_count;
    end
  end

  assign o_rand_step     = (r_state == StStep);
  assign o_wall_valid    = (r_state == StOffer);
  assign o_wall_height   = r_height;
  assign o_wall_fallback = r_fallback;
  assign o_missed_spawn  = r_missed;
  assign o_spawn_count   = r_spawn_count;

endmodule

// File: tb/tb_wall_spawn_ctrl.sv
// Scoreboard bench for wall_spawn_ctrl: LFSR stand-in feeds queued samples, monitor checks walls.
module tb_wall_spawn_ctrl;

  logic       clk = 1'b0;
  logic       i_reset, i_enable, i_frame_tick, i_wall_ready;
  logic [5:0] i_rand_in;
  logic       o_rand_step, o_wall_valid, o_wall_fallback, o_missed_spawn;
  logic [5:0] o_wall_height;
  logic [7:0] o_spawn_count;

  typedef struct packed {
    logic [5:0] h;
    logic       fb;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] rand_q[$];
  int         total = 0;
  int         bad = 0;
  int         steps = 0;
  int         misses = 0;

  always #5 clk = ~clk;

  wall_spawn_ctrl #(.SPAWN_PERIOD(4)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_frame_tick   (i_frame_tick),
    .i_rand_in      (i_rand_in),
    .o_rand_step    (o_rand_step),
    .i_wall_ready   (i_wall_ready),
    .o_wall_valid   (o_wall_valid),
    .o_wall_height  (o_wall_height),
    .o_wall_fallback(o_wall_fallback),
    .o_missed_spawn (o_missed_spawn),
    .o_spawn_count  (o_spawn_count)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rand_step"}, int'(o_rand_step), 0);
    chk({tag, "_wall_valid"}, int'(o_wall_valid), 0);
    chk({tag, "_wall_height"}, int'(o_wall_height), 0);
    chk({tag, "_wall_fallback"}, int'(o_wall_fallback), 0);
    chk({tag, "_missed_spawn"}, int'(o_missed_spawn), 0);
    chk({tag, "_spawn_count"}, int'(o_spawn_count), 0);
  endtask

  // Restart from IDLE with samples already queued; expects one accepted wall.
  task automatic run_spawn(input logic [5:0] h, input logic fb, input int exp_steps,
                           input int exp_lat);
    int s0;
    int lat;
    exp_q.push_back(exp_t'{h: h, fb: fb, cnt: 8'd0});
    i_enable = 1'b0;
    step();
    i_enable = 1'b1;
    s0  = steps;
    lat = 0;
    while (!o_wall_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("latency", lat, exp_lat);
    step();
    chk("rand_step_pulses", steps - s0, exp_steps);
    chk("count_after_accept", int'(o_spawn_count), 1);
  endtask

  // LFSR stand-in: the new sample appears in the cycle after each rand_step.
  initial begin
    forever begin
      @(negedge clk);
      if (o_rand_step === 1'b1) begin
        steps++;
        if (rand_q.size() > 0) i_rand_in = rand_q.pop_front();
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_missed_spawn === 1'b1) misses++;
      if (o_wall_valid === 1'b1 && i_wall_ready && i_enable && !i_reset) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wall: got height %0d, no wall expected", o_wall_height);
        end else begin
          e = exp_q.pop_front();
          chk("wall_height", int'(o_wall_height), int'(e.h));
          chk("wall_fallback", int'(o_wall_fallback), int'(e.fb));
          chk("spawn_count_at_offer", int'(o_spawn_count), int'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0;
    int lat;
    i_reset = 1'b1;
    i_enable = 1'b0;
    i_frame_tick = 1'b0;
    i_wall_ready = 1'b0;
    i_rand_in = 6'd0;
    step();
    step();
    chk_all_zero("reset");
    i_reset = 1'b0;
    step();
    chk_all_zero("idle");

    // First wall, accepted on first sample, ready already high.
    rand_q.push_back(6'd25);
    exp_q.push_back(exp_t'{h: 6'd25, fb: 1'b0, cnt: 8'd0});
    i_enable = 1'b1;
    i_wall_ready = 1'b1;
    step();
    chk("c1_rand_step", int'(o_rand_step), 1);
    chk("c1_wall_valid", int'(o_wall_valid), 0);
    step();
    chk("c2_rand_step", int'(o_rand_step), 0);
    chk("c2_wall_valid", int'(o_wall_valid), 0);
    step();
    chk("c3_wall_valid", int'(o_wall_valid), 1);
    chk("c3_rand_step", int'(o_rand_step), 0);
    step();
    chk("c4_wall_valid", int'(o_wall_valid), 0);
    chk("c4_spawn_count", int'(o_spawn_count), 1);
    chk("c4_rand_steps", steps, 1);

    // All samples rejected -> fallback after 4 draws.
    rand_q.push_back(6'd50);
    rand_q.push_back(6'd63);
    rand_q.push_back(6'd2);
    rand_q.push_back(6'd41);
    run_spawn(6'd20, 1'b1, 4, 9);

    // Range boundaries.
    rand_q.push_back(6'd3);
    rand_q.push_back(6'd4);
    run_spawn(6'd4, 1'b0, 2, 5);
    rand_q.push_back(6'd41);
    rand_q.push_back(6'd40);
    run_spawn(6'd40, 1'b0, 2, 5);
    rand_q.push_back(6'd4);
    run_spawn(6'd4, 1'b0, 1, 3);
    rand_q.push_back(6'd40);
    run_spawn(6'd40, 1'b0, 1, 3);

    // Periodic spawning, 4 ticks per period, ticks 3 cycles apart.
    m0 = misses;
    for (int j = 0; j < 3; j++) begin
      rand_q.push_back(6'(10 + j));
      exp_q.push_back(exp_t'{h: 6'(10 + j), fb: 1'b0, cnt: 8'(1 + j)});
    end
    for (int j = 0; j < 3; j++) begin
      for (int t = 1; t <= 4; t++) begin
        tick();
        chk("period_rand_step", int'(o_rand_step), (t == 4) ? 1 : 0);
        step();
        step();
      end
    end
    step();
    chk("period_count", int'(o_spawn_count), 4);
    chk("period_no_miss", misses - m0, 0);

    // Backpressure across two expiries.
    m0 = misses;
    i_wall_ready = 1'b0;
    rand_q.push_back(6'd30);
    exp_q.push_back(exp_t'{h: 6'd30, fb: 1'b0, cnt: 8'd4});
    repeat (4) begin
      tick();
      step();
    end
    step();
    chk("bp_valid", int'(o_wall_valid), 1);
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("bp_hold_valid", int'(o_wall_valid), 1);
      chk("bp_hold_height", int'(o_wall_height), 30);
    end
    step();
    chk("bp_missed", misses - m0, 2);
    i_wall_ready = 1'b1;
    step();
    chk("bp_count", int'(o_spawn_count), 5);
    chk("bp_valid_after", int'(o_wall_valid), 0);

    // Abort in OFFER.
    i_wall_ready = 1'b0;
    rand_q.push_back(6'd33);
    i_enable = 1'b0;
    step();
    i_enable = 1'b1;
    lat = 0;
    while (!o_wall_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("abort_offer_latency", lat, 3);
    i_enable = 1'b0;
    step();
    chk("abort_valid", int'(o_wall_valid), 0);
    chk("abort_rand_step", int'(o_rand_step), 0);
    chk("abort_height_kept", int'(o_wall_height), 33);
    step();
    chk("abort_idle_valid", int'(o_wall_valid), 0);

    // Reset during SAMPLE.
    rand_q.push_back(6'd7);
    i_enable = 1'b1;
    step();
    step();
    i_reset = 1'b1;
    step();
    chk_all_zero("midreset");
    i_reset = 1'b0;
    i_enable = 1'b0;
    step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
